// File: rtl/inst_fetch.sv
// Instruction fetch stage: small loadable program memory that streams one
// word per unstalled cycle to the decoder and fills every idle cycle with NOP.
module inst_fetch #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [15:0]   load_data,
   input  logic          start,
   input  logic          stall,
   output logic [15:0]   inst,
   output logic          inst_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   issued_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [15:0]   NOP_WORD  = 16'h0100;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PC_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

   state_t        state_r, state_s;
   logic [AW-1:0] pc_r, pc_s;
   logic [AW:0]   cnt_r, cnt_s;
   logic [15:0]   inst_r, inst_s;
   logic          valid_r, valid_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic [15:0]   mem_r [DEPTH];
   logic [15:0]   word_s;

   function automatic logic is_halt(input logic [15:0] w);
      return w[15:12] == 4'hF;
   endfunction

   // Program memory write port, locked out while running; contents survive reset.
   always_ff @(posedge clk) begin
      if (load_en && (state_r != RUN)) begin
         mem_r[load_addr] <= load_data;
      end
   end

   assign word_s = mem_r[pc_r];

   // Next-state and next-output logic.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      cnt_s   = cnt_r;
      inst_s  = NOP_WORD;
      valid_s = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_s = RUN;
               pc_s    = {AW{1'b0}};
               cnt_s   = {(AW + 1){1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         RUN: begin
            if (stall) begin
               state_s = RUN;
            end else if (is_halt(word_s)) begin
               // HALT is consumed silently; pc stays on it for inspection.
               state_s = DONE;
            end else begin
               inst_s  = word_s;
               valid_s = 1'b1;
               cnt_s   = cnt_r + CNT_ONE;
               if (pc_r == LAST_ADDR) begin
                  state_s = DONE;
               end else begin
                  pc_s = pc_r + PC_ONE;
               end
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s == RUN);
      done_s = (state_s == DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         pc_r    <= {AW{1'b0}};
         cnt_r   <= {(AW + 1){1'b0}};
         inst_r  <= NOP_WORD;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         cnt_r   <= cnt_s;
         inst_r  <= inst_s;
         valid_r <= valid_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign inst       = inst_r;
   assign inst_valid = valid_r;
   assign pc         = pc_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign issued_cnt = cnt_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with hand-computed expectations.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [15:0] load_data;
   logic        start;
   logic        stall;
   logic [15:0] inst;
   logic        inst_valid;
   logic [3:0]  pc;
   logic        busy;
   logic        done;
   logic [4:0]  issued_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   inst_fetch #(.DEPTH(16), .AW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start),
      .stall      (stall),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc),
      .busy       (busy),
      .done       (done),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic kick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic issue(input string tag, input logic [15:0] w, input logic [3:0] p, input logic [4:0] c);
      tick();
      chk({tag, "_inst"}, 32'(inst), 32'(w));
      chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
      chk({tag, "_pc"}, 32'(pc), 32'(p));
      chk({tag, "_cnt"}, 32'(issued_cnt), 32'(c));
   endtask

   task automatic expect_done(input string tag, input logic [3:0] p, input logic [4:0] c);
      chk({tag, "_inst"}, 32'(inst), 32'h0100);
      chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_pc"}, 32'(pc), 32'(p));
      chk({tag, "_cnt"}, 32'(issued_cnt), 32'(c));
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_data = 16'd0;
      start = 1'b0; stall = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_inst", 32'(inst), 32'h0100);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(issued_cnt), 32'd0);

      // HALT-terminated program
      load(4'd0, 16'h1200);
      load(4'd1, 16'h2A05);
      load(4'd2, 16'h3412);
      load(4'd3, 16'hF000);
      kick();
      chk("halt_busy", 32'(busy), 32'd1);
      chk("halt_e0_inst", 32'(inst), 32'h0100);
      chk("halt_e0_valid", 32'(inst_valid), 32'd0);
      issue("halt_w0", 16'h1200, 4'd1, 5'd1);
      chk("halt_w0_done", 32'(done), 32'd0);
      issue("halt_w1", 16'h2A05, 4'd2, 5'd2);
      issue("halt_w2", 16'h3412, 4'd3, 5'd3);
      tick();
      expect_done("halt_end", 4'd3, 5'd3);
      tick();
      expect_done("halt_hold", 4'd3, 5'd3);

      // Two-cycle stall after first issue
      kick();
      issue("stall_w0", 16'h1200, 4'd1, 5'd1);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("stall_b%0d_inst", i), 32'(inst), 32'h0100);
         chk($sformatf("stall_b%0d_valid", i), 32'(inst_valid), 32'd0);
         chk($sformatf("stall_b%0d_pc", i), 32'(pc), 32'd1);
         chk($sformatf("stall_b%0d_cnt", i), 32'(issued_cnt), 32'd1);
      end
      stall = 1'b0;
      issue("stall_w1", 16'h2A05, 4'd2, 5'd2);
      issue("stall_w2", 16'h3412, 4'd3, 5'd3);
      tick();
      expect_done("stall_end", 4'd3, 5'd3);

      // Write during RUN is dropped
      kick();
      load_en = 1'b1; load_addr = 4'd2; load_data = 16'h5555;
      issue("lrun_w0", 16'h1200, 4'd1, 5'd1);
      load_en = 1'b0;
      issue("lrun_w1", 16'h2A05, 4'd2, 5'd2);
      issue("lrun_w2", 16'h3412, 4'd3, 5'd3);
      tick();
      expect_done("lrun_end", 4'd3, 5'd3);

      // Write in DONE coincident with start is seen by the fetch
      load_en = 1'b1; load_addr = 4'd2; load_data = 16'h5555;
      kick();
      load_en = 1'b0;
      issue("ldone_w0", 16'h1200, 4'd1, 5'd1);
      issue("ldone_w1", 16'h2A05, 4'd2, 5'd2);
      issue("ldone_w2", 16'h5555, 4'd3, 5'd3);
      tick();
      expect_done("ldone_end", 4'd3, 5'd3);

      // Asynchronous reset mid-run
      kick();
      issue("rrun_w0", 16'h1200, 4'd1, 5'd1);
      issue("rrun_w1", 16'h2A05, 4'd2, 5'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_inst", 32'(inst), 32'h0100);
      chk("arst_valid", 32'(inst_valid), 32'd0);
      chk("arst_pc", 32'(pc), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_cnt", 32'(issued_cnt), 32'd0);
      rst = 1'b0;
      tick();
      chk("arst_idle_busy", 32'(busy), 32'd0);
      chk("arst_idle_valid", 32'(inst_valid), 32'd0);
      kick();
      issue("rre_w0", 16'h1200, 4'd1, 5'd1);
      issue("rre_w1", 16'h2A05, 4'd2, 5'd2);
      issue("rre_w2", 16'h5555, 4'd3, 5'd3);
      tick();
      expect_done("rre_end", 4'd3, 5'd3);

      // End of memory without HALT
      for (int a = 0; a < 16; a++) load(4'(a), 16'h1000);
      kick();
      for (int i = 0; i < 16; i++) begin
         issue($sformatf("eom_w%0d", i), 16'h1000, (i < 15) ? 4'(i + 1) : 4'd15, 5'(i + 1));
         chk($sformatf("eom_w%0d_done", i), 32'(done), (i == 15) ? 32'd1 : 32'd0);
      end
      tick();
      expect_done("eom_end", 4'd15, 5'd16);
      tick();
      expect_done("eom_nowrap", 4'd15, 5'd16);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the SIMD ALU, directly upstream of the instruction decoder. It holds a small program memory, loaded through a write port while idle. On `start` it streams one 16-bit instruction per cycle into the decoder's `inst` input. Because the decoder samples `inst` on every clock, every cycle with nothing to issue (idle, stalled, halted) is filled with the canonical NOP word. Fetch stops on a HALT opcode or at the end of memory.

## Interface
- `DEPTH`, 16: program memory words; power of two, ≥ 2.
- `AW`, 4: address width; equals log2(DEPTH).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_en` in 1: program-memory write strobe.
- `load_addr` in AW: write address.
- `load_data` in 16: write data.
- `start` in 1: begin execution at address 0.
- `stall` in 1: downstream cannot accept; insert a bubble and hold PC.
- `inst` out 16: instruction word to the decoder.
- `inst_valid` out 1: `inst` carries a fetched program word, not a bubble.
- `pc` out AW: address of the next word to fetch.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE.
- `issued_cnt` out AW+1: count of words issued since the last `start`.

## Operation
- NOP bubble word is 16'h0100: opcode 0, mode 0, imm_flag 1, imm 0.
- HALT is any word with [15:12] == 4'hF.
- States are IDLE, RUN and DONE; outputs are registered.
- **Reset values:** state IDLE, `pc` 0, `inst` 16'h0100, `inst_valid` 0, `issued_cnt` 0, `busy` 0, `done` 0. Memory contents are not reset.
- **Loading:**
  - `load_en` writes `mem[load_addr] <= load_data` in IDLE or DONE.
  - In RUN, `load_en` is ignored and memory is unchanged.
- **IDLE:**
  - `inst` = NOP, `inst_valid` = 0.
  - `start` = 1 → RUN; `pc` <= 0; `issued_cnt` <= 0.
- **RUN, `stall` = 1:**
  - `inst` <= NOP, `inst_valid` <= 0.
  - `pc` and `issued_cnt` hold.
  - No HALT or end-of-memory check is made.
- **RUN, `stall` = 0, `mem[pc]` is HALT:**
  - `inst` <= NOP, `inst_valid` <= 0; state → DONE.
  - `pc` holds at the HALT address.
  - HALT is never issued and is not counted.
- **RUN, `stall` = 0, word is not HALT:**
  - `inst` <= `mem[pc]`, `inst_valid` <= 1, `issued_cnt` += 1.
  - If `pc` == DEPTH-1: state → DONE and `pc` holds at DEPTH-1 (no wrap).
  - Otherwise `pc` += 1.
- **DONE:**
  - `inst` = NOP, `inst_valid` = 0.
  - `pc` and `issued_cnt` hold, so software can read the final count.
  - `start` → RUN, with `pc` and `issued_cnt` cleared.
- `start` asserted during RUN is ignored.
- `load_en` and `start` in the same IDLE/DONE cycle: the write completes at that edge, so a first fetch of that address sees the new data.
- `issued_cnt` width AW+1 holds the maximum of DEPTH; it never wraps.

## Timing
- `start` is sampled at edge E0; `busy` rises after E0.
- Fetch from address 0 happens at E1, so `mem[0]` appears on `inst` after E1. This is two edges from `start` sampling.
- Throughput is one instruction per unstalled cycle.
- `stall` sampled high at edge E makes `inst` a bubble after E, with no lookahead. Issue resumes at the first edge where `stall` is low, from the held `pc`.
- On the final issued word, `done` and that word's `inst_valid` rise after the same edge. `inst` becomes NOP one edge later.
- On HALT, `done` rises after the edge that detects HALT, with `inst` already NOP.
- Decoder output follows `inst` by one more cycle (its own register). End-to-end, `start` to decoded `mem[0]` takes three edges.
- `rst` is asynchronous:
  - Asserting it mid-RUN forces all outputs to reset values immediately, independent of `clk`.
  - After deassertion the block is IDLE and requires a new `start`.
  - Memory keeps its prior contents.

## Test plan
- **Reset:** assert `rst` between clock edges. Outputs go to `inst` = 16'h0100, `inst_valid` 0, `pc` 0, `busy` 0, `done` 0 without a clock edge.
- **HALT run:** load 16'h1200, 16'h2A05, 16'h3412, 16'hF000 at addresses 0–3, then `start`.
  - Over three consecutive edges `inst` = 16'h1200, 16'h2A05, 16'h3412, each with `inst_valid` 1.
  - Next, `inst` = 16'h0100 and `done` = 1.
  - Final `pc` = 3, `issued_cnt` = 3.
- **Stall:** same program, `stall` = 1 for 2 cycles after the first issue.
  - Two 16'h0100 bubbles with `inst_valid` 0; `pc` holds at 1.
  - Issue then resumes with 16'h2A05.
  - Final `issued_cnt` = 3.
- **End of memory:** fill all 16 words with 16'h1000 (no HALT), then `start`.
  - 16 issues, then `done` = 1, `pc` = 15, `issued_cnt` = 16.
  - No wrap to address 0.
- **Load in RUN:** `load_en` to address 2 with 16'h5555 mid-run is ignored; address 2 still issues its old word. The same write in DONE followed by `start` issues 16'h5555 at address 2.
- **Reset mid-run:** assert `rst` after 2 issues, deassert, `start` again. Execution restarts at address 0, `issued_cnt` counts from 0, and memory is intact.
